// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit: one shift-add (MULT) or restoring-subtract
// (DIV) step per cycle, with results handed back as HI/LO over a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam int         CW      = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_dvd;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_is_div;
  logic               w_start_ok;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_lo_div;
  logic [WIDTH-1:0]   w_hi_div;
  logic [WIDTH-1:0]   w_dvd_orig;

  assign w_is_div   = (alu_op == OP_DIV);
  assign w_start_ok = start && ((alu_op == OP_MULT) || w_is_div);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_abs_a    = a[WIDTH-1] ? -a : a;
  assign w_abs_b    = b[WIDTH-1] ? -b : b;
  assign busy       = (r_state != S_IDLE);

  // MULT: acc = {partial product, remaining multiplier bits}; add on LSB, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // DIV: remainder stays below |b| <= 2^(WIDTH-1), so the shifted remainder fits in WIDTH bits.
  assign w_rem_sh   = {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh, r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quot     = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo_div   = r_neg_res ? -w_quot : w_quot;
  assign w_hi_div   = r_neg_dvd ? -w_rem : w_rem;
  // On divide-by-zero the low half still holds |a|; re-apply the sign to recover a.
  assign w_dvd_orig = r_neg_dvd ? -w_quot : w_quot;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = (w_is_div && (b == '0)) ? S_FIX : S_CALC;
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_div    <= 1'b0;
      r_neg_res   <= 1'b0;
      r_neg_dvd   <= 1'b0;
      r_dbz       <= 1'b0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      r_state     <= w_next;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_is_div  <= w_is_div;
            r_neg_dvd <= a[WIDTH-1];
            r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            r_dbz     <= w_is_div && (b == '0);
            r_cnt     <= '0;
            if (w_is_div) begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd <= w_abs_a;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
        S_FIX: begin
          done <= 1'b1;
          if (r_dbz) begin
            hi          <= w_dvd_orig;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (r_is_div) begin
            hi <= w_hi_div;
            lo <= w_lo_div;
          end else begin
            {hi, lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written handshake/reset sequences.
module tb_muldiv_unit;

  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam int NORMAL_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  alu_op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed reference arithmetic straight from the operation definitions.
  function automatic void model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint p, q, r;
    z = 1'b0;
    if (op == MULT) begin
      p = longint'($signed(x)) * longint'($signed(y));
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Pulse start for one edge (E0); operands are scrambled afterwards to prove they are captured.
  task automatic launch(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; alu_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; alu_op = 6'($urandom); a = $urandom; b = $urandom;
  endtask

  // Called #1 after E0; lat = edges after E0 until done is seen, -1 on timeout.
  task automatic wait_done(output int lat, output int bcnt,
                           output logic [31:0] h, output logic [31:0] l, output logic z);
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    h = hi; l = lo; z = div_by_zero;
  endtask

  vec_t        vecs [10];
  int          lat, bcnt, exp_lat, dcnt;
  logic [31:0] rh, rl, eh, el, ra, rb, save_hi, save_lo;
  logic        rz, ez;
  logic [5:0]  rop;

  initial begin
    vecs[0] = '{MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3] = '{MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[4] = '{DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[5] = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{DIV,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{DIV,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[9] = '{DIV,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt, rh, rl, rz);
      exp_lat = vecs[i].dbz ? 1 : NORMAL_LAT;
      check($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
      check($sformatf("vec%0d_dbz", i), rz, vecs[i].dbz);
      check($sformatf("vec%0d_lat", i), lat, exp_lat);
      check($sformatf("vec%0d_busycnt", i), bcnt, exp_lat);
      check($sformatf("vec%0d_busy_at_done", i), busy, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_dbz_pulse", i), div_by_zero, 0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? MULT : DIV;
      ra  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($signed($urandom_range(0, 40)) - 20);
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, eh, el, ez);
      launch(rop, ra, rb);
      wait_done(lat, bcnt, rh, rl, rz);
      check($sformatf("rnd%0d_hi", i), rh, eh);
      check($sformatf("rnd%0d_lo", i), rl, el);
      check($sformatf("rnd%0d_dbz", i), rz, ez);
      check($sformatf("rnd%0d_lat", i), lat, ez ? 1 : NORMAL_LAT);
    end

    // start while busy is ignored and not queued
    launch(MULT, 32'd7, 32'hFFFF_FFFD);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; alu_op = MULT; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt, rh, rl, rz);
    check("midstart_lat", lat, NORMAL_LAT - 10);
    check("midstart_hi", rh, 32'hFFFF_FFFF);
    check("midstart_lo", rl, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("midstart_not_queued", busy, 0);

    // Back-to-back: second start issued in the done cycle of the first
    launch(MULT, 32'd3, 32'd4);
    wait_done(lat, bcnt, rh, rl, rz);
    check("b2b_first_lo", rl, 32'd12);
    check("b2b_first_hi", rh, 32'd0);
    launch(DIV, 32'd100, 32'hFFFF_FFF9);
    wait_done(lat, bcnt, rh, rl, rz);
    check("b2b_second_lat", lat, NORMAL_LAT);
    check("b2b_second_lo", rl, 32'hFFFF_FFF2);
    check("b2b_second_hi", rh, 32'd2);

    // Invalid alu_op does nothing; hi/lo hold
    save_hi = hi; save_lo = lo;
    launch(6'b100000, 32'd9, 32'd9);
    check("badop_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("badop_busy_later", busy, 0);
    check("hold_hi", hi, save_hi);
    check("hold_lo", lo, save_lo);

    // Asynchronous reset in the middle of a DIV
    launch(DIV, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("no_done_after_rst", dcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
